// File: rtl/proc_pkg.sv
// ============================================================================
//  Module      : proc_pkg
//  Description : Shared processor definitions: bus width defaults, the
//                data-memory responder state encoding and load/store opcodes.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package proc_pkg;

    localparam int DMEM_DATA_W = 32;
    localparam int DMEM_ADDR_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

    // The core's memory stage decodes these into req_valid/req_write.
    localparam logic [5:0] OP_LW = 6'b100011;
    localparam logic [5:0] OP_SW = 6'b101011;

endpackage

`default_nettype wire

// File: rtl/dmem_array.sv
// ============================================================================
//  Module      : dmem_array
//  Description : DEPTH x DATA_W word storage, synchronous write and
//                registered read. Contents are not reset.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_array
    import proc_pkg::*;
#(
    parameter int DATA_W = DMEM_DATA_W,
    parameter int DEPTH  = 256
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [$clog2(DEPTH)-1:0]   widx,
    input  logic [DATA_W-1:0]          wdata,
    input  logic                       re,
    input  logic [$clog2(DEPTH)-1:0]   ridx,
    output logic [DATA_W-1:0]          rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[widx] <= wdata;
        end
        if (re) begin
            rdata <= mem_q[ridx];
        end
    end

endmodule

`default_nettype wire

// File: rtl/dmem_responder.sv
// ============================================================================
//  Module      : dmem_responder
//  Description : Single-outstanding data-memory responder. Accepts a load or
//                store, waits LATENCY cycles, then answers from dmem_array.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_responder
    import proc_pkg::*;
#(
    parameter int DATA_W  = DMEM_DATA_W,
    parameter int ADDR_W  = DMEM_ADDR_W,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int         IDX_W    = $clog2(DEPTH);
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    dmem_state_e       state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              err_q, err_d;

    logic              enter_resp;
    logic              addr_err;
    logic              mem_we;
    logic              mem_re;
    logic [DATA_W-1:0] mem_rdata;

    // Misaligned, or any address bit above the word index is set.
    assign addr_err = (addr_q[1:0] != 2'b00) || (addr_q[ADDR_W-1:IDX_W+2] != '0);

    // Storage is touched only on the edge that enters RESP; a reset on that
    // edge aborts the request, so the write is suppressed as well.
    assign mem_we = enter_resp && write_q  && !addr_err && !reset;
    assign mem_re = enter_resp && !write_q && !addr_err && !reset;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        write_d    = write_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        err_d      = err_q;
        enter_resp = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    write_d = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    cnt_d   = CNT_INIT;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // WAIT always lasts LATENCY cycles, LATENCY==1 included,
                // so rsp_valid follows the accept edge by exactly LATENCY.
                if (cnt_q == 4'd0) begin
                    enter_resp = 1'b1;
                    err_d      = addr_err;
                    state_d    = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    err_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end

    dmem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk    (clk),
        .we     (mem_we),
        .widx   (addr_q[IDX_W+1:2]),
        .wdata  (wdata_q),
        .re     (mem_re),
        .ridx   (addr_q[IDX_W+1:2]),
        .rdata  (mem_rdata)
    );

    // The array read register holds its value until the next load, so the
    // load data stays stable for as long as RESP waits on rsp_ready.
    assign req_ready = (state_q == IDLE) && !reset;
    assign rsp_valid = (state_q == RESP);
    assign rsp_err   = err_q;
    assign rsp_rdata = (rsp_valid && !write_q && !err_q) ? mem_rdata : '0;

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// ============================================================================
//  Module      : tb_dmem_responder
//  Description : Randomized self-checking bench for dmem_responder at
//                LATENCY 2, 1, 4 and 15 against a word-array reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_dmem_responder;

    localparam int N_INST = 4;
    localparam int DEPTH  = 256;

    function automatic int lat_of(input int i);
        case (i)
            0:       return 2;
            1:       return 1;
            2:       return 4;
            default: return 15;
        endcase
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset;
    logic              rsp_ready;
    logic              req_write;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic [N_INST-1:0] req_valid;
    logic [N_INST-1:0] req_ready;
    logic [N_INST-1:0] rsp_valid;
    logic [N_INST-1:0] rsp_err;
    logic [31:0]       rsp_rdata [N_INST];

    generate
        for (genvar gi = 0; gi < N_INST; gi++) begin : g_dut
            dmem_responder #(
                .DATA_W  (32),
                .ADDR_W  (32),
                .DEPTH   (DEPTH),
                .LATENCY (lat_of(gi))
            ) u_dut (
                .clk       (clk),
                .reset     (reset),
                .req_valid (req_valid[gi]),
                .req_ready (req_ready[gi]),
                .req_write (req_write),
                .req_addr  (req_addr),
                .req_wdata (req_wdata),
                .rsp_valid (rsp_valid[gi]),
                .rsp_ready (rsp_ready),
                .rsp_rdata (rsp_rdata[gi]),
                .rsp_err   (rsp_err[gi])
            );
        end
    endgenerate

    // Reference storage per instance; words never stored are unknown.
    logic [31:0] model_mem [N_INST][DEPTH];
    bit          model_vld [N_INST][DEPTH];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rand_addr();
        int          r;
        logic [31:0] a;
        r = $urandom_range(0, 7);
        a = 32'($urandom_range(0, 15)) << 2;
        if (r == 0)      a = a | 32'($urandom_range(1, 3));
        else if (r == 1) a = ($urandom() | 32'h400) & ~32'h3;
        return a;
    endfunction

    // One complete request/response, checking timing, data and stall hold.
    task automatic run_txn(input int sel, input bit wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input int stall, input bit rst_wait);
        int          lat;
        int          idx;
        bit          exp_err;
        bit          chk_rd;
        logic [31:0] exp_rd;
        lat     = lat_of(sel);
        exp_err = (addr[1:0] != 2'b00) || (addr >= 32'(DEPTH * 4));
        idx     = int'(addr >> 2) % DEPTH;

        @(negedge clk);
        check("idle_ready", 32'(req_ready[sel]), 1);
        req_valid[sel] = 1'b1;
        req_write      = wr;
        req_addr       = addr;
        req_wdata      = wdata;
        rsp_ready      = (stall == 0);

        for (int c = 0; c < lat; c++) begin
            @(negedge clk);
            if (c == 0) begin
                req_valid[sel] = 1'b0;
                req_write      = ~wr;
                req_addr       = $urandom();
                req_wdata      = $urandom();
            end
            check("wait_valid", 32'(rsp_valid[sel]), 0);
            check("wait_ready", 32'(req_ready[sel]), 0);
            if (rst_wait) begin
                reset = 1'b1;
                @(negedge clk);
                check("rst_valid", 32'(rsp_valid[sel]), 0);
                check("rst_ready", 32'(req_ready[sel]), 0);
                check("rst_err",   32'(rsp_err[sel]),   0);
                check("rst_rdata", rsp_rdata[sel],      0);
                reset     = 1'b0;
                rsp_ready = 1'b1;
                return;
            end
        end

        if (wr || exp_err) begin
            chk_rd = 1'b1;
            exp_rd = 32'h0;
        end else begin
            chk_rd = model_vld[sel][idx];
            exp_rd = model_mem[sel][idx];
        end

        @(negedge clk);
        check("rsp_valid", 32'(rsp_valid[sel]), 1);
        check("rsp_err",   32'(rsp_err[sel]),   32'(exp_err));
        if (chk_rd) check("rsp_rdata", rsp_rdata[sel], exp_rd);
        if (wr && !exp_err) begin
            model_mem[sel][idx] = wdata;
            model_vld[sel][idx] = 1'b1;
        end

        // An intruding store held through RESP and the handshake cycle
        // must not be taken.
        req_valid[sel] = 1'b1;
        req_write      = 1'b1;
        req_addr       = 32'($urandom_range(0, 15)) << 2;
        req_wdata      = $urandom();

        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check("stall_valid", 32'(rsp_valid[sel]), 1);
            check("stall_ready", 32'(req_ready[sel]), 0);
            check("stall_err",   32'(rsp_err[sel]),   32'(exp_err));
            if (chk_rd) check("stall_rdata", rsp_rdata[sel], exp_rd);
        end
        rsp_ready = 1'b1;

        @(negedge clk);
        check("post_valid", 32'(rsp_valid[sel]), 0);
        check("post_err",   32'(rsp_err[sel]),   0);
        check("post_rdata", rsp_rdata[sel],      0);
        check("post_ready", 32'(req_ready[sel]), 1);
        req_valid[sel] = 1'b0;
    endtask

    // Back-to-back loads with rsp_ready=1: each request needs LATENCY cycles
    // to respond, one RESP handshake cycle and one IDLE accept cycle.
    task automatic measure_period(input int sel);
        int lat;
        int rises[$];
        bit prev;
        lat       = lat_of(sel);
        prev      = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        req_valid[sel] = 1'b1;
        req_write      = 1'b0;
        req_addr       = 32'h0;
        for (int c = 0; c < 4 * (lat + 2) + 4; c++) begin
            @(negedge clk);
            if (rsp_valid[sel] && !prev) rises.push_back(c);
            prev = rsp_valid[sel];
        end
        req_valid[sel] = 1'b0;
        check("b2b_count", 32'(rises.size() >= 3), 1);
        for (int i = 1; i < rises.size(); i++) begin
            check("b2b_period", 32'(rises[i] - rises[i-1]), 32'(lat + 2));
        end
        repeat (lat + 4) @(negedge clk);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        rsp_ready = 1'b1;
        req_valid = '0;
        req_write = 1'b0;
        req_addr  = 32'h0;
        req_wdata = 32'h0;

        repeat (2) begin
            @(negedge clk);
            for (int i = 0; i < N_INST; i++) begin
                check("reset_ready", 32'(req_ready[i]), 0);
                check("reset_valid", 32'(rsp_valid[i]), 0);
                check("reset_err",   32'(rsp_err[i]),   0);
                check("reset_rdata", rsp_rdata[i],      0);
            end
        end
        reset = 1'b0;
        #1;
        for (int i = 0; i < N_INST; i++) begin
            check("after_reset_ready", 32'(req_ready[i]), 1);
        end

        for (int sel = 0; sel < N_INST; sel++) begin
            run_txn(sel, 1'b1, 32'h10,  32'hDEADBEEF, 0, 1'b0);
            run_txn(sel, 1'b0, 32'h10,  32'h0,        0, 1'b0);
            run_txn(sel, 1'b0, 32'h13,  32'h0,        0, 1'b0);
            run_txn(sel, 1'b0, 32'h400, 32'h0,        0, 1'b0);
            run_txn(sel, 1'b0, 32'h10,  32'h0,        5, 1'b0);
            run_txn(sel, 1'b1, 32'h20,  32'hA5A5A5A5, 0, 1'b0);
            run_txn(sel, 1'b1, 32'h20,  32'h12345678, 0, 1'b1);
            run_txn(sel, 1'b0, 32'h20,  32'h0,        1, 1'b0);
            repeat (30) begin
                run_txn(sel, 1'($urandom_range(0, 1)), rand_addr(), $urandom(),
                        $urandom_range(0, 3), ($urandom_range(0, 9) == 0));
            end
            measure_period(sel);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
